// File: rtl/qoi_types.sv
// Shared QOI types, op tag constants and the pixel hash used by both codec directions.
package qoi_types;

  typedef logic [7:0]  byte_t;
  typedef logic [2:0]  addr_t;
  typedef logic [29:0] size_t;
  typedef logic [5:0]  index_t;

  typedef struct packed {
    byte_t r;
    byte_t g;
    byte_t b;
    byte_t a;
  } pixel_t;

  localparam byte_t      QOI_OP_RGB   = 8'hFE;
  localparam byte_t      QOI_OP_RGBA  = 8'hFF;
  localparam logic [1:0] QOI_OP_INDEX = 2'b00;
  localparam logic [1:0] QOI_OP_DIFF  = 2'b01;
  localparam logic [1:0] QOI_OP_LUMA  = 2'b10;
  localparam logic [1:0] QOI_OP_RUN   = 2'b11;

  localparam pixel_t PX_INIT = 32'h0000_00FF;

  localparam addr_t ADDR_DATA  = 3'd0;
  localparam addr_t ADDR_PIXEL = 3'd1;
  localparam addr_t ADDR_CTRL  = 3'd3;

  // Multi-byte op being collected while in ARG.
  typedef enum logic [1:0] {OPK_RGB, OPK_RGBA, OPK_LUMA} op_kind_t;

  // Only the low 6 bits survive, so an 11-bit intermediate is enough.
  function automatic index_t qoi_hash(input pixel_t p);
    logic [10:0] s;
    s = 11'(p.r) * 11'd3 + 11'(p.g) * 11'd5 + 11'(p.b) * 11'd7 + 11'(p.a) * 11'd11;
    return s[5:0];
  endfunction

endpackage

// File: rtl/qoi_decoder_if.sv
// CPU register-window bus seen by the QOI decoder.
interface qoi_decoder_if;
  logic                cs;
  logic                we;
  qoi_types::addr_t    addr;
  qoi_types::byte_t    data_i;
  qoi_types::byte_t    data_o;

  modport master (output cs, output we, output addr, output data_i, input data_o);
  modport slave  (input cs, input we, input addr, input data_i, output data_o);
endinterface

// File: rtl/qoi_index_ram.sv
// 64-entry pixel index: async clear on reset, sync clear on start, comb read, sync write.
module qoi_index_ram
  import qoi_types::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   clr,
  input  logic   we,
  input  index_t waddr,
  input  pixel_t wdata,
  input  index_t raddr,
  output pixel_t rdata
);

  pixel_t mem [64];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/qoi_decoder.sv
// Memory-mapped QOI decoder: CPU feeds encoded bytes, reads back RGBA pixels byte by byte.
//   state  | meaning
//   IDLE   | waiting for start
//   TAG    | expecting an op tag byte
//   ARG    | collecting argument bytes of RGB/RGBA/LUMA
//   EMIT   | pixel available, CPU reads r,g,b,a
//   DONE   | size pixels consumed, count held
module qoi_decoder
  import qoi_types::*;
(
  input logic          clk,
  input logic          rst,
  qoi_decoder_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_TAG, S_ARG, S_EMIT, S_DONE} state_t;

  state_t     state, state_nxt;
  size_t      size_r, count, count_inc;
  logic [5:0] run, luma_g;
  logic [1:0] out_idx, arg_idx;
  op_kind_t   op, op_nxt;
  byte_t      arg_r, arg_g, arg_b, tag, dg, data_o;
  pixel_t     px, prev_px, px_nxt, idx_rdata;
  logic       wr, rd, wr_data, wr_start, rd_px, arg_final, count_hit;
  logic       px_load, px_done, run_load, in_ready, px_valid, working;

  assign wr        = bus.cs & bus.we;
  assign rd        = bus.cs & ~bus.we;
  assign tag       = bus.data_i;
  assign wr_data   = wr && (bus.addr == ADDR_DATA);
  assign wr_start  = wr && (bus.addr == ADDR_CTRL) && bus.data_i[7]
                     && (state == S_IDLE || state == S_DONE);
  assign rd_px     = rd && (bus.addr == ADDR_PIXEL) && (state == S_EMIT);
  assign count_inc = count + 30'd1;
  assign count_hit = (count_inc == size_r);
  assign arg_final = (op == OPK_LUMA) || (op == OPK_RGB && arg_idx == 2'd2)
                     || (op == OPK_RGBA && arg_idx == 2'd3);
  assign dg        = {2'b00, luma_g} - 8'd32;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    px_nxt    = px;
    px_load   = 1'b0;
    px_done   = 1'b0;
    run_load  = 1'b0;
    op_nxt    = op;
    in_ready  = 1'b0;
    px_valid  = 1'b0;
    working   = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (wr_start) state_nxt = (size_r == '0) ? S_DONE : S_TAG;
      end
      S_TAG: begin
        working  = 1'b1;
        in_ready = 1'b1;
        if (wr_data) begin
          // The two 8-bit tags must win over the 11xxxxxx RUN pattern.
          if (tag == QOI_OP_RGB) begin
            op_nxt    = OPK_RGB;
            state_nxt = S_ARG;
          end else if (tag == QOI_OP_RGBA) begin
            op_nxt    = OPK_RGBA;
            state_nxt = S_ARG;
          end else begin
            state_nxt = S_EMIT;
            px_load   = 1'b1;
            case (tag[7:6])
              QOI_OP_INDEX: px_nxt = idx_rdata;
              QOI_OP_DIFF: begin
                px_nxt.r = prev_px.r + {6'b0, tag[5:4]} - 8'd2;
                px_nxt.g = prev_px.g + {6'b0, tag[3:2]} - 8'd2;
                px_nxt.b = prev_px.b + {6'b0, tag[1:0]} - 8'd2;
                px_nxt.a = prev_px.a;
              end
              QOI_OP_LUMA: begin
                op_nxt    = OPK_LUMA;
                state_nxt = S_ARG;
                px_load   = 1'b0;
              end
              QOI_OP_RUN: begin
                px_nxt   = prev_px;
                run_load = 1'b1;
              end
              default: ;
            endcase
          end
        end
      end
      S_ARG: begin
        working  = 1'b1;
        in_ready = 1'b1;
        if (wr_data && arg_final) begin
          px_load   = 1'b1;
          state_nxt = S_EMIT;
          case (op)
            OPK_RGB: begin
              px_nxt.r = arg_r;
              px_nxt.g = arg_g;
              px_nxt.b = tag;
              px_nxt.a = prev_px.a;
            end
            OPK_RGBA: begin
              px_nxt.r = arg_r;
              px_nxt.g = arg_g;
              px_nxt.b = arg_b;
              px_nxt.a = tag;
            end
            OPK_LUMA: begin
              px_nxt.r = prev_px.r + dg + {4'b0, tag[7:4]} - 8'd8;
              px_nxt.g = prev_px.g + dg;
              px_nxt.b = prev_px.b + dg + {4'b0, tag[3:0]} - 8'd8;
              px_nxt.a = prev_px.a;
            end
            default: ;
          endcase
        end
      end
      S_EMIT: begin
        working  = 1'b1;
        px_valid = 1'b1;
        if (rd_px && out_idx == 2'd3) begin
          px_done = 1'b1;
          if (count_hit)     state_nxt = S_DONE;
          else if (run == 0) state_nxt = S_TAG;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      size_r  <= '0;
      count   <= '0;
      run     <= '0;
      luma_g  <= '0;
      out_idx <= '0;
      arg_idx <= '0;
      op      <= OPK_RGB;
      arg_r   <= '0;
      arg_g   <= '0;
      arg_b   <= '0;
      px      <= '0;
      prev_px <= PX_INIT;
    end else begin
      op <= op_nxt;
      if (wr && bus.addr[2]) begin
        case (bus.addr[1:0])
          2'd0: size_r[7:0]   <= bus.data_i;
          2'd1: size_r[15:8]  <= bus.data_i;
          2'd2: size_r[23:16] <= bus.data_i;
          default: size_r[29:24] <= bus.data_i[5:0];
        endcase
      end
      if (wr_start) begin
        count   <= '0;
        run     <= '0;
        out_idx <= '0;
        arg_idx <= '0;
        prev_px <= PX_INIT;
      end
      if (state == S_TAG && wr_data) begin
        arg_idx <= '0;
        luma_g  <= bus.data_i[5:0];
      end
      if (run_load) run <= bus.data_i[5:0];
      if (state == S_ARG && wr_data) begin
        case (arg_idx)
          2'd0: arg_r <= bus.data_i;
          2'd1: arg_g <= bus.data_i;
          2'd2: arg_b <= bus.data_i;
          default: ;
        endcase
        arg_idx <= arg_idx + 2'd1;
      end
      if (px_load) px <= px_nxt;
      if (rd_px) out_idx <= out_idx + 2'd1;
      if (px_done) begin
        prev_px <= px;
        count   <= count_inc;
        // A run that would overshoot size is simply dropped at DONE.
        if (count_hit)     run <= '0;
        else if (run != 0) run <= run - 6'd1;
      end
    end
  end

  qoi_index_ram u_index (
    .clk   (clk),
    .rst   (rst),
    .clr   (wr_start),
    .we    (px_done),
    .waddr (qoi_hash(px)),
    .wdata (px),
    .raddr (bus.data_i[5:0]),
    .rdata (idx_rdata)
  );

  always_comb begin
    data_o = '0;
    case (bus.addr)
      ADDR_PIXEL: begin
        if (state == S_EMIT) begin
          case (out_idx)
            2'd0: data_o = px.r;
            2'd1: data_o = px.g;
            2'd2: data_o = px.b;
            default: data_o = px.a;
          endcase
        end
      end
      ADDR_CTRL: data_o = {working, 3'b000, out_idx, px_valid, in_ready};
      3'd4:      data_o = count[7:0];
      3'd5:      data_o = count[15:8];
      3'd6:      data_o = count[23:16];
      3'd7:      data_o = {2'b00, count[29:24]};
      default:   data_o = '0;
    endcase
  end

  assign bus.data_o = data_o;

endmodule

// File: tb/tb_qoi_decoder.sv
// Directed bench for qoi_decoder: expected pixel bytes queued by stimulus, checked by a bus monitor.
module tb_qoi_decoder;
  import qoi_types::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  qoi_decoder_if bus ();

  qoi_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int    tests = 0;
  int    fails = 0;
  byte_t exp_q[$];
  byte_t d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_wr(input addr_t a, input byte_t v);
    @(negedge clk);
    bus.cs = 1'b1; bus.we = 1'b1; bus.addr = a; bus.data_i = v;
    @(negedge clk);
    bus.cs = 1'b0; bus.we = 1'b0;
  endtask

  task automatic rd_reg(input addr_t a, output byte_t v);
    @(negedge clk);
    bus.cs = 1'b1; bus.we = 1'b0; bus.addr = a;
    #1 v = bus.data_o;
    @(negedge clk);
    bus.cs = 1'b0;
  endtask

  // Queue the expected byte, then issue the pixel-port read the monitor will check.
  task automatic exp_px(input byte_t e);
    byte_t dummy;
    exp_q.push_back(e);
    rd_reg(ADDR_PIXEL, dummy);
  endtask

  task automatic exp_pixel(input byte_t r, input byte_t g, input byte_t b, input byte_t a);
    exp_px(r); exp_px(g); exp_px(b); exp_px(a);
  endtask

  task automatic set_size(input logic [31:0] n);
    bus_wr(3'd4, n[7:0]);
    bus_wr(3'd5, n[15:8]);
    bus_wr(3'd6, n[23:16]);
    bus_wr(3'd7, n[31:24]);
  endtask

  task automatic start();
    bus_wr(ADDR_CTRL, 8'h80);
  endtask

  task automatic chk_reg(input string name, input addr_t a, input byte_t e);
    byte_t v;
    rd_reg(a, v);
    check(name, v, e);
  endtask

  initial begin : monitor
    byte_t e;
    forever begin
      @(negedge clk);
      #2;
      if (bus.cs && !bus.we && bus.addr == ADDR_PIXEL) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL px_unexpected: got 0x%0h expected no read", bus.data_o);
        end else begin
          e = exp_q.pop_front();
          check("px_byte", bus.data_o, e);
        end
      end
    end
  end

  initial begin
    bus.cs = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.data_i = '0;
    repeat (3) @(negedge clk);
    chk_reg("rst_status", ADDR_CTRL, 8'h00);
    chk_reg("rst_count", 3'd4, 8'h00);
    exp_px(8'h00);
    @(negedge clk) rst = 1'b1;

    // single RGB pixel
    set_size(1);
    start();
    chk_reg("t1_status_tag", ADDR_CTRL, 8'h81);
    start();
    chk_reg("t1_start_ignored", ADDR_CTRL, 8'h81);
    bus_wr(0, 8'hFE); bus_wr(0, 8'h10); bus_wr(0, 8'h20); bus_wr(0, 8'h30);
    chk_reg("t1_status_emit", ADDR_CTRL, 8'h82);
    exp_px(8'h10);
    chk_reg("t1_status_idx1", ADDR_CTRL, 8'h86);
    exp_px(8'h20); exp_px(8'h30); exp_px(8'hFF);
    chk_reg("t1_status_done", ADDR_CTRL, 8'h00);
    chk_reg("t1_count", 3'd4, 8'h01);

    // RGB, DIFF, LUMA, INDEX
    set_size(4);
    start();
    bus_wr(0, 8'hFE); bus_wr(0, 8'h10); bus_wr(0, 8'h20); bus_wr(0, 8'h30);
    exp_pixel(8'h10, 8'h20, 8'h30, 8'hFF);
    bus_wr(0, 8'h79);
    exp_pixel(8'h11, 8'h20, 8'h2F, 8'hFF);
    bus_wr(0, 8'h9E); bus_wr(0, 8'hA6);
    exp_pixel(8'h11, 8'h1E, 8'h2B, 8'hFF);
    bus_wr(0, 8'h15);
    exp_pixel(8'h10, 8'h20, 8'h30, 8'hFF);
    chk_reg("t2_status_done", ADDR_CTRL, 8'h00);
    chk_reg("t2_count", 3'd4, 8'h04);

    // DIFF wrap from the initial previous pixel
    set_size(1);
    start();
    bus_wr(0, 8'h4A);
    exp_pixel(8'hFE, 8'h00, 8'h00, 8'hFF);
    chk_reg("t3_status_done", ADDR_CTRL, 8'h00);

    // RUN expansion
    set_size(4);
    start();
    bus_wr(0, 8'hFE); bus_wr(0, 8'h01); bus_wr(0, 8'h02); bus_wr(0, 8'h03);
    exp_pixel(8'h01, 8'h02, 8'h03, 8'hFF);
    bus_wr(0, 8'hC2);
    for (int i = 0; i < 3; i++) begin
      chk_reg("t4_status_run", ADDR_CTRL, 8'h82);
      exp_pixel(8'h01, 8'h02, 8'h03, 8'hFF);
    end
    chk_reg("t4_status_done", ADDR_CTRL, 8'h00);
    chk_reg("t4_count", 3'd4, 8'h04);

    // run truncated by size, later writes ignored
    set_size(2);
    start();
    bus_wr(0, 8'hFE); bus_wr(0, 8'h05); bus_wr(0, 8'h05); bus_wr(0, 8'h05);
    exp_pixel(8'h05, 8'h05, 8'h05, 8'hFF);
    bus_wr(0, 8'hC4);
    exp_pixel(8'h05, 8'h05, 8'h05, 8'hFF);
    chk_reg("t5_status_done", ADDR_CTRL, 8'h00);
    chk_reg("t5_count", 3'd4, 8'h02);
    bus_wr(0, 8'h00);
    chk_reg("t5_status_ignored", ADDR_CTRL, 8'h00);
    exp_px(8'h00);
    chk_reg("t5_count_held", 3'd4, 8'h02);

    // reset in the middle of an RGB op
    set_size(1);
    start();
    bus_wr(0, 8'hFE); bus_wr(0, 8'h10);
    chk_reg("t6_status_arg", ADDR_CTRL, 8'h81);
    @(negedge clk) rst = 1'b0;
    chk_reg("t6_status_rst", ADDR_CTRL, 8'h00);
    @(negedge clk) rst = 1'b1;
    set_size(1);
    start();
    bus_wr(0, 8'hFE); bus_wr(0, 8'h10); bus_wr(0, 8'h20); bus_wr(0, 8'h30);
    exp_pixel(8'h10, 8'h20, 8'h30, 8'hFF);
    chk_reg("t6_status_done", ADDR_CTRL, 8'h00);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
